// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// per-requester completion pulses and a PREADY timeout so a stuck slave cannot hang the bus.
module apb_master_arb #(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*AWIDTH-1:0]   req_addr,
    input  logic [2*DWIDTH-1:0]   req_wdata,
    output logic [1:0]            req_ack,
    output logic [1:0]            rsp_valid,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [AWIDTH-1:0]     PADDR,
    output logic [DWIDTH-1:0]     PWDATA,
    input  logic [DWIDTH-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic [CW-1:0]       r_cnt,         w_cnt_nxt;
    logic                r_last_grant,  w_last_grant_nxt;
    logic                r_grant,       w_grant_nxt;
    logic                r_psel,        w_psel_nxt;
    logic                r_penable,     w_penable_nxt;
    logic                r_pwrite,      w_pwrite_nxt;
    logic [AWIDTH-1:0]   r_paddr,       w_paddr_nxt;
    logic [DWIDTH-1:0]   r_pwdata,      w_pwdata_nxt;
    logic [1:0]          r_ack,         w_ack_nxt;
    logic [1:0]          r_rsp_valid,   w_rsp_valid_nxt;
    logic [DWIDTH-1:0]   r_rsp_rdata,   w_rsp_rdata_nxt;
    logic                r_rsp_err,     w_rsp_err_nxt;

    logic                w_pick;
    logic [1:0]          w_owner_onehot;

    // On a tie the requester that did not win last time gets the bus.
    assign w_pick         = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_owner_onehot = r_grant ? 2'b10 : 2'b01;

    // NOTE: every next-value is given a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_psel_nxt       = r_psel;
        w_penable_nxt    = r_penable;
        w_pwrite_nxt     = r_pwrite;
        w_paddr_nxt      = r_paddr;
        w_pwdata_nxt     = r_pwdata;
        w_ack_nxt        = 2'b00;
        w_rsp_valid_nxt  = 2'b00;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_rsp_err_nxt    = r_rsp_err;

        case (r_state)
            ST_IDLE: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                if (|req_valid) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_pwrite_nxt     = w_pick ? req_write[1] : req_write[0];
                    w_paddr_nxt      = w_pick ? req_addr[AWIDTH +: AWIDTH]
                                              : req_addr[0 +: AWIDTH];
                    w_pwdata_nxt     = w_pick ? req_wdata[DWIDTH +: DWIDTH]
                                              : req_wdata[0 +: DWIDTH];
                    w_psel_nxt       = 1'b1;
                    w_ack_nxt        = w_pick ? 2'b10 : 2'b01;
                    w_state_nxt      = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // PREADY is checked first so a completion on the last allowed cycle is not aborted.
                if (PREADY) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = w_owner_onehot;
                    w_rsp_err_nxt   = PSLVERR;
                    w_rsp_rdata_nxt = (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                    w_state_nxt     = ST_IDLE;
                end else if (r_cnt == CNT_LIMIT) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = w_owner_onehot;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_ack        <= 2'b00;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_psel       <= w_psel_nxt;
            r_penable    <= w_penable_nxt;
            r_pwrite     <= w_pwrite_nxt;
            r_paddr      <= w_paddr_nxt;
            r_pwdata     <= w_pwdata_nxt;
            r_ack        <= w_ack_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign req_ack   = r_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a cycle table for single transfers plus
// hand-written sequences for arbitration, timeout and reset corner cases.
module tb_apb_master_arb;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ack, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [7:0]  PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_arb #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(4)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end (time %0t)", $time);
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  prdata;
        logic        pready;
        logic        pslverr;
        logic        e_psel;
        logic        e_penable;
        logic        e_pwrite;
        logic [3:0]  e_paddr;
        logic [7:0]  e_pwdata;
        logic [1:0]  e_ack;
        logic [1:0]  e_rspv;
        logic [7:0]  e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic psel, input logic pen,
                              input logic pwr, input logic [3:0] paddr,
                              input logic [7:0] pwdata, input logic [1:0] ack,
                              input logic [1:0] rspv, input logic [7:0] rdata,
                              input logic err);
        check({tag, ".psel"},    32'(PSEL),      32'(psel));
        check({tag, ".penable"}, 32'(PENABLE),   32'(pen));
        check({tag, ".pwrite"},  32'(PWRITE),    32'(pwr));
        check({tag, ".paddr"},   32'(PADDR),     32'(paddr));
        check({tag, ".pwdata"},  32'(PWDATA),    32'(pwdata));
        check({tag, ".ack"},     32'(req_ack),   32'(ack));
        check({tag, ".rspv"},    32'(rsp_valid), 32'(rspv));
        check({tag, ".rdata"},   32'(rsp_rdata), 32'(rdata));
        check({tag, ".err"},     32'(rsp_err),   32'(err));
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Four ACCESS cycles with PREADY low, then PREADY=last_ready on the 4th.
    task automatic run_timeout(input string tag, input logic [3:0] addr,
                               input logic last_ready, input logic [7:0] rd,
                               input logic exp_err, input logic [7:0] exp_rdata);
        req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, addr};
        PREADY = 1'b0; PRDATA = 8'h99; PSLVERR = 1'b0;
        step();
        check({tag, ".setup_psel"}, 32'(PSEL), 32'd1);
        check({tag, ".setup_pen"},  32'(PENABLE), 32'd0);
        check({tag, ".setup_ack"},  32'(req_ack), 32'd1);
        req_valid = 2'b00;
        for (int a = 0; a < 4; a++) begin
            step();
            check($sformatf("%s.access%0d_psel", tag, a), 32'(PSEL), 32'd1);
            check($sformatf("%s.access%0d_pen", tag, a), 32'(PENABLE), 32'd1);
        end
        PREADY = last_ready; PRDATA = rd;
        step();
        check({tag, ".end_psel"},  32'(PSEL), 32'd0);
        check({tag, ".end_pen"},   32'(PENABLE), 32'd0);
        check({tag, ".end_rspv"},  32'(rsp_valid), 32'd1);
        check({tag, ".end_err"},   32'(rsp_err), 32'(exp_err));
        check({tag, ".end_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        PREADY = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = 8'h00;
        req_wdata = 16'h0000; PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;

        //          rst valid  write  addr   wdata      prd    rdy  err | psel pen pwr paddr pwdata ack    rspv   rdata  err
        vecs[0]  = '{1, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   0, 0, 0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[1]  = '{1, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   0, 0, 0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[2]  = '{0, 2'b01, 2'b01, 8'h03, 16'h00A5, 8'h00, 1, 0,   1, 0, 1, 4'h3, 8'hA5, 2'b01, 2'b00, 8'h00, 0};
        vecs[3]  = '{0, 2'b00, 2'b00, 8'h03, 16'h00A5, 8'h00, 1, 0,   1, 1, 1, 4'h3, 8'hA5, 2'b00, 2'b00, 8'h00, 0};
        vecs[4]  = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'hEE, 1, 0,   0, 0, 1, 4'h3, 8'hA5, 2'b00, 2'b01, 8'h00, 0};
        vecs[5]  = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   0, 0, 1, 4'h3, 8'hA5, 2'b00, 2'b00, 8'h00, 0};
        vecs[6]  = '{0, 2'b10, 2'b00, 8'h60, 16'h7700, 8'h00, 0, 0,   1, 0, 0, 4'h6, 8'h77, 2'b10, 2'b00, 8'h00, 0};
        vecs[7]  = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   1, 1, 0, 4'h6, 8'h77, 2'b00, 2'b00, 8'h00, 0};
        vecs[8]  = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   1, 1, 0, 4'h6, 8'h77, 2'b00, 2'b00, 8'h00, 0};
        vecs[9]  = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   1, 1, 0, 4'h6, 8'h77, 2'b00, 2'b00, 8'h00, 0};
        vecs[10] = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h3C, 1, 0,   0, 0, 0, 4'h6, 8'h77, 2'b00, 2'b10, 8'h3C, 0};
        vecs[11] = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   0, 0, 0, 4'h6, 8'h77, 2'b00, 2'b00, 8'h3C, 0};
        vecs[12] = '{0, 2'b01, 2'b00, 8'h07, 16'h0011, 8'hFF, 1, 1,   1, 0, 0, 4'h7, 8'h11, 2'b01, 2'b00, 8'h3C, 0};
        vecs[13] = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'hFF, 1, 1,   1, 1, 0, 4'h7, 8'h11, 2'b00, 2'b00, 8'h3C, 0};
        vecs[14] = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'hFF, 1, 1,   0, 0, 0, 4'h7, 8'h11, 2'b00, 2'b01, 8'h00, 1};
        vecs[15] = '{0, 2'b00, 2'b00, 8'h00, 16'h0000, 8'h00, 0, 0,   0, 0, 0, 4'h7, 8'h11, 2'b00, 2'b00, 8'h00, 1};

        // Single transfers: reset, write, read with wait states, slave error.
        for (int i = 0; i < 16; i++) begin
            PRESET    = vecs[i].rst;
            req_valid = vecs[i].valid;
            req_write = vecs[i].write;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            PRDATA    = vecs[i].prdata;
            PREADY    = vecs[i].pready;
            PSLVERR   = vecs[i].pslverr;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_psel, vecs[i].e_penable,
                       vecs[i].e_pwrite, vecs[i].e_paddr, vecs[i].e_pwdata,
                       vecs[i].e_ack, vecs[i].e_rspv, vecs[i].e_rdata, vecs[i].e_err);
        end

        // Arbitration: both requesters held valid from reset; expect 0,1,0,1.
        PRESET = 1'b1; req_valid = 2'b11; req_write = 2'b01;
        req_addr = {4'h9, 4'h2}; req_wdata = {8'h81, 8'h5A};
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 8'h6B;
        step();
        step();
        check_outs("arb_reset", 0, 0, 0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 0);
        PRESET = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int k;
            int g;
            k = i % 3;
            g = (i / 3) % 2;
            step();
            check($sformatf("arb%0d.ack", i),  32'(req_ack),   (k == 0) ? (32'd1 << g) : 32'd0);
            check($sformatf("arb%0d.psel", i), 32'(PSEL),      (k != 2) ? 32'd1 : 32'd0);
            check($sformatf("arb%0d.pen", i),  32'(PENABLE),   (k == 1) ? 32'd1 : 32'd0);
            check($sformatf("arb%0d.rspv", i), 32'(rsp_valid), (k == 2) ? (32'd1 << g) : 32'd0);
            check($sformatf("arb%0d.paddr", i), 32'(PADDR),    (g == 1) ? 32'h9 : 32'h2);
            if (k == 2)
                check($sformatf("arb%0d.rdata", i), 32'(rsp_rdata), (g == 1) ? 32'h6B : 32'h00);
        end
        req_valid = 2'b00;
        step();
        check("arb_idle.psel", 32'(PSEL), 32'd0);

        // Timeout after 4 ACCESS cycles, then PREADY arriving on the 4th cycle wins.
        run_timeout("tmo_abort", 4'h4, 1'b0, 8'h99, 1'b1, 8'h00);
        step();
        run_timeout("tmo_ready", 4'h5, 1'b1, 8'h42, 1'b0, 8'h42);
        step();

        // Reset during ACCESS drops the transfer; req0 is re-granted afterwards.
        req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h01; req_wdata = 16'h00C3;
        PREADY = 1'b0; PSLVERR = 1'b0;
        step();
        check("rst_mid.setup_ack", 32'(req_ack), 32'd1);
        step();
        check("rst_mid.access_pen", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        step();
        check_outs("rst_mid.in_reset", 0, 0, 0, 4'h0, 8'h00, 2'b00, 2'b00, 8'h00, 0);
        step();
        check("rst_mid.hold_rspv", 32'(rsp_valid), 32'd0);
        PRESET = 1'b0;
        step();
        check_outs("rst_mid.regrant", 1, 0, 1, 4'h1, 8'hC3, 2'b01, 2'b00, 8'h00, 0);
        req_valid = 2'b00; PREADY = 1'b1;
        step();
        check("rst_mid.access2_pen", 32'(PENABLE), 32'd1);
        step();
        check("rst_mid.done_rspv", 32'(rsp_valid), 32'd1);
        check("rst_mid.done_err",  32'(rsp_err),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
